// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults, address-width helper and write-port bundle
//               for the multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_NREGS = 32;
  localparam int DEFAULT_NREAD = 2;

  function automatic int rf_aw(input int nregs);
    return $clog2(nregs);
  endfunction

  localparam int DEFAULT_AW = rf_aw(DEFAULT_NREGS);

  typedef struct packed {
    logic                     we;
    logic [DEFAULT_AW-1:0]    wa;
    logic [DEFAULT_WIDTH-1:0] wd;
  } rf_wport_t;

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// Module      : rf_scoreboard
// Description : Per-register pending-write bitmap for RAW hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = DEFAULT_NREGS,
  parameter int ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         iss_v,
  input  logic [rf_aw(NREGS)-1:0]      iss_a,
  input  logic [1:0]                   we,
  input  logic [2*rf_aw(NREGS)-1:0]    wa,
  output logic [NREGS-1:0]             pending
);

  localparam int AW = rf_aw(NREGS);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_nxt;

  // A new issue to r supersedes a writeback retiring the older producer.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int r = 0; r < NREGS; r++) begin
      if (iss_v && (iss_a == AW'(r))) begin
        w_pending_nxt[r] = 1'b1;
      end else if ((we[0] && (wa[0 +: AW] == AW'(r))) ||
                   (we[1] && (wa[AW +: AW] == AW'(r)))) begin
        w_pending_nxt[r] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      w_pending_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign pending = r_pending;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module      : regfile_mp
// Description : Multi-port register file, 2 write / NREAD read ports, optional
//               write-first bypass, hardwired zero register and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NREGS    = DEFAULT_NREGS,
  parameter int NREAD    = DEFAULT_NREAD,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    we,
  input  logic [2*rf_aw(NREGS)-1:0]     wa,
  input  logic [2*WIDTH-1:0]            wd,
  input  logic [NREAD*rf_aw(NREGS)-1:0] ra,
  output logic [NREAD*WIDTH-1:0]        rd,
  output logic [NREAD-1:0]              busy,
  input  logic                          iss_v,
  input  logic [rf_aw(NREGS)-1:0]       iss_a
);

  localparam int AW = rf_aw(NREGS);

  logic [WIDTH-1:0] r_rf [NREGS];
  logic [NREGS-1:0] w_pending;
  logic [AW-1:0]    w_wa0, w_wa1;
  logic [WIDTH-1:0] w_wd0, w_wd1;
  logic             w_wr0, w_wr1;

  assign w_wa0 = wa[0  +: AW];
  assign w_wa1 = wa[AW +: AW];
  assign w_wd0 = wd[0     +: WIDTH];
  assign w_wd1 = wd[WIDTH +: WIDTH];

  assign w_wr0 = we[0] && !((ZERO_REG != 0) && (w_wa0 == '0));
  assign w_wr1 = we[1] && !((ZERO_REG != 0) && (w_wa1 == '0));

  // Port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        r_rf[r] <= '0;
      end
    end else begin
      if (w_wr0) r_rf[w_wa0] <= w_wd0;
      if (w_wr1) r_rf[w_wa1] <= w_wd1;
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk     (clk),
    .reset   (reset),
    .iss_v   (iss_v),
    .iss_a   (iss_a),
    .we      (we),
    .wa      (wa),
    .pending (w_pending)
  );

  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [AW-1:0]    w_ra;
    logic             w_hit0, w_hit1;
    logic [WIDTH-1:0] w_rd;

    assign w_ra   = ra[k*AW +: AW];
    assign w_hit0 = we[0] && (w_wa0 == w_ra);
    assign w_hit1 = we[1] && (w_wa1 == w_ra);

    always_comb begin
      w_rd = r_rf[w_ra];
      if ((ZERO_REG != 0) && (w_ra == '0)) begin
        w_rd = '0;
      end else if ((BYPASS != 0) && w_hit1) begin
        w_rd = w_wd1;
      end else if ((BYPASS != 0) && w_hit0) begin
        w_rd = w_wd0;
      end
    end

    assign rd[k*WIDTH +: WIDTH] = w_rd;
    // A bypassed writeback already delivers the value, so the hazard is gone.
    assign busy[k] = w_pending[w_ra] && !((BYPASS != 0) && (w_hit0 || w_hit1));
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed and randomized checks of regfile_mp builds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Wide builds: A = bypass + zero reg, B = no bypass, no zero reg
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic [9:0]  ra;
  logic        iss_v;
  logic [4:0]  iss_a;
  logic [63:0] a_rd, b_rd;
  logic [1:0]  a_busy, b_busy;

  // Narrow builds: P = bypass + zero reg, Q = no bypass, no zero reg
  logic [1:0]  p_we;
  logic [7:0]  p_wa;
  logic [15:0] p_wd;
  logic [15:0] p_ra;
  logic        p_iss_v;
  logic [3:0]  p_iss_a;
  logic [31:0] p_rd, q_rd;
  logic [3:0]  p_busy, q_busy;

  regfile_mp #(.WIDTH(32), .NREGS(32), .NREAD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .rd(a_rd), .busy(a_busy), .iss_v(iss_v), .iss_a(iss_a));

  regfile_mp #(.WIDTH(32), .NREGS(32), .NREAD(2), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .rd(b_rd), .busy(b_busy), .iss_v(iss_v), .iss_a(iss_a));

  regfile_mp #(.WIDTH(8), .NREGS(16), .NREAD(4), .BYPASS(1), .ZERO_REG(1)) dut_p (
    .clk(clk), .reset(reset), .we(p_we), .wa(p_wa), .wd(p_wd), .ra(p_ra),
    .rd(p_rd), .busy(p_busy), .iss_v(p_iss_v), .iss_a(p_iss_a));

  regfile_mp #(.WIDTH(8), .NREGS(16), .NREAD(4), .BYPASS(0), .ZERO_REG(0)) dut_q (
    .clk(clk), .reset(reset), .we(p_we), .wa(p_wa), .wd(p_wd), .ra(p_ra),
    .rd(q_rd), .busy(q_busy), .iss_v(p_iss_v), .iss_a(p_iss_a));

  // Reference model for P (index 0) and Q (index 1)
  logic [7:0] m_rf   [2][16];
  bit         m_pend [2][16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we = 2'b00; wa = '0; wd = '0; iss_v = 1'b0; iss_a = '0;
  endtask

  task automatic model_clear();
    for (int n = 0; n < 2; n++)
      for (int r = 0; r < 16; r++) begin
        m_rf[n][r]   = 8'h00;
        m_pend[n][r] = 1'b0;
      end
  endtask

  task automatic model_step();
    int a0, a1;
    a0 = int'(p_wa[3:0]);
    a1 = int'(p_wa[7:4]);
    for (int n = 0; n < 2; n++) begin
      bit zero;
      zero = (n == 0);
      for (int r = 0; r < 16; r++) begin
        if (p_iss_v && int'(p_iss_a) == r && !(zero && r == 0))
          m_pend[n][r] = 1'b1;
        else if ((p_we[0] && a0 == r) || (p_we[1] && a1 == r))
          m_pend[n][r] = 1'b0;
      end
      if (p_we[0] && !(zero && a0 == 0)) m_rf[n][a0] = p_wd[7:0];
      if (p_we[1] && !(zero && a1 == 0)) m_rf[n][a1] = p_wd[15:8];
    end
  endtask

  task automatic compare_pq(input int step);
    for (int n = 0; n < 2; n++) begin
      bit zero, byp;
      zero = (n == 0);
      byp  = (n == 0);
      for (int k = 0; k < 4; k++) begin
        int         a;
        bit         hit0, hit1;
        logic [7:0] exp_rd;
        logic       exp_busy;
        logic [7:0] obs_rd;
        logic       obs_busy;
        a    = int'(p_ra[k*4 +: 4]);
        hit0 = p_we[0] && int'(p_wa[3:0]) == a;
        hit1 = p_we[1] && int'(p_wa[7:4]) == a;
        if (zero && a == 0)   exp_rd = 8'h00;
        else if (byp && hit1) exp_rd = p_wd[15:8];
        else if (byp && hit0) exp_rd = p_wd[7:0];
        else                  exp_rd = m_rf[n][a];
        exp_busy = m_pend[n][a] && !(byp && (hit0 || hit1));
        obs_rd   = (n == 0) ? p_rd[k*8 +: 8] : q_rd[k*8 +: 8];
        obs_busy = (n == 0) ? p_busy[k] : q_busy[k];
        check($sformatf("rnd%0d_%s_rd%0d", step, (n == 0) ? "p" : "q", k),
              {24'h0, obs_rd}, {24'h0, exp_rd});
        check($sformatf("rnd%0d_%s_busy%0d", step, (n == 0) ? "p" : "q", k),
              {31'h0, obs_busy}, {31'h0, exp_busy});
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    ra = '0;
    p_we = '0; p_wa = '0; p_wd = '0; p_ra = '0; p_iss_v = 1'b0; p_iss_a = '0;
    model_clear();

    @(negedge clk); #1;
    check("rst_a_rd", a_rd[31:0], 32'h0);
    check("rst_a_busy", {30'h0, a_busy}, 32'h0);
    check("rst_b_busy", {30'h0, b_busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Fill r1..r5, issue r4, then reset mid-cycle
    we = 2'b11; wa = {5'd2, 5'd1}; wd = {32'hA2, 32'hA1};
    @(negedge clk);
    wa = {5'd4, 5'd3}; wd = {32'hA4, 32'hA3};
    @(negedge clk);
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hA5}; iss_v = 1'b1; iss_a = 5'd4;
    @(negedge clk);
    idle(); ra = {5'd5, 5'd4}; #1;
    check("fill_a_rd4", a_rd[31:0], 32'hA4);
    check("fill_a_busy4", {31'h0, a_busy[0]}, 32'h1);
    check("fill_a_rd5", a_rd[63:32], 32'hA5);
    check("fill_b_rd4", b_rd[31:0], 32'hA4);
    #1 reset = 1'b1; #1;
    check("rstmid_a_rd0", a_rd[31:0], 32'h0);
    check("rstmid_a_rd1", a_rd[63:32], 32'h0);
    check("rstmid_a_busy", {30'h0, a_busy}, 32'h0);
    check("rstmid_b_rd0", b_rd[31:0], 32'h0);
    check("rstmid_b_busy", {30'h0, b_busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0; #1;
    check("postrst_a_rd0", a_rd[31:0], 32'h0);
    check("postrst_a_rd1", a_rd[63:32], 32'h0);

    // Dual write collision on r7
    @(negedge clk);
    we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h2222, 32'h1111}; ra = {5'd0, 5'd7}; #1;
    check("coll_a_bypass", a_rd[31:0], 32'h2222);
    check("coll_b_old", b_rd[31:0], 32'h0);
    @(negedge clk);
    idle(); #1;
    check("coll_a_rd7", a_rd[31:0], 32'h2222);
    check("coll_b_rd7", b_rd[31:0], 32'h2222);
    check("coll_a_busy7", {31'h0, a_busy[0]}, 32'h0);

    // Same-cycle read of a write
    @(negedge clk);
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h1234};
    @(negedge clk);
    wd = {32'h0, 32'hDEAD}; ra = {5'd0, 5'd3}; #1;
    check("byp_a_rd3", a_rd[31:0], 32'hDEAD);
    check("byp_b_rd3_old", b_rd[31:0], 32'h1234);
    @(negedge clk);
    idle(); #1;
    check("byp_b_rd3_new", b_rd[31:0], 32'hDEAD);

    // Register zero
    @(negedge clk);
    we = 2'b01; wa = '0; wd = {32'h0, 32'hFFFF_FFFF}; iss_v = 1'b1; iss_a = 5'd0; ra = '0; #1;
    check("zero_a_rd_same", a_rd[31:0], 32'h0);
    check("zero_a_busy_same", {31'h0, a_busy[0]}, 32'h0);
    @(negedge clk);
    idle(); #1;
    check("zero_a_rd", a_rd[31:0], 32'h0);
    check("zero_a_busy", {31'h0, a_busy[0]}, 32'h0);
    check("zero_b_rd", b_rd[31:0], 32'hFFFF_FFFF);
    check("zero_b_busy", {31'h0, b_busy[0]}, 32'h1);

    // Scoreboard on r9
    @(negedge clk);
    iss_v = 1'b1; iss_a = 5'd9; ra = {5'd0, 5'd9}; #1;
    check("sb_a_busy_before", {31'h0, a_busy[0]}, 32'h0);
    @(negedge clk);
    idle(); #1;
    check("sb_a_busy_issued", {31'h0, a_busy[0]}, 32'h1);
    check("sb_b_busy_issued", {31'h0, b_busy[0]}, 32'h1);
    @(negedge clk);
    we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h55}; #1;
    check("sb_a_busy_wb", {31'h0, a_busy[0]}, 32'h0);
    check("sb_b_busy_wb", {31'h0, b_busy[0]}, 32'h1);
    check("sb_a_rd_wb", a_rd[31:0], 32'h55);
    @(negedge clk);
    idle(); #1;
    check("sb_a_busy_clr", {31'h0, a_busy[0]}, 32'h0);
    check("sb_b_busy_clr", {31'h0, b_busy[0]}, 32'h0);
    @(negedge clk);
    iss_v = 1'b1; iss_a = 5'd9; we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h66};
    @(negedge clk);
    idle(); #1;
    check("sb_a_busy_both", {31'h0, a_busy[0]}, 32'h1);
    check("sb_b_busy_both", {31'h0, b_busy[0]}, 32'h1);
    check("sb_a_rd_both", a_rd[31:0], 32'h66);

    // Randomized stream on the narrow builds, with one mid-cycle reset
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 400; i++) begin
      p_we    = 2'($urandom_range(0, 3));
      p_wa    = 8'($urandom);
      p_wd    = 16'($urandom);
      p_ra    = 16'($urandom);
      p_iss_v = 1'($urandom_range(0, 1));
      p_iss_a = 4'($urandom);
      #1;
      compare_pq(i);
      if (i == 200) begin
        #1 reset = 1'b1; #1;
        model_clear();
        compare_pq(10000 + i);
        @(negedge clk);
        reset = 1'b0;
      end else begin
        model_step();
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
